// File: rtl/spi_cmd_pkg.sv
// Opcodes, word width and frame-length lookup for the pan/tilt SPI command protocol.
// The same package is used by the FPGA-side command slave.
package spi_cmd_pkg;

   localparam int MSG_WIDTH = 8;

   localparam logic [7:0] RESET_CMD      = 8'hFF;
   localparam logic [7:0] SET_PITCH_CMD  = 8'h11;
   localparam logic [7:0] GET_PITCH_CMD  = 8'h12;
   localparam logic [7:0] SET_YAW_CMD    = 8'h21;
   localparam logic [7:0] GET_YAW_CMD    = 8'h22;
   localparam logic [7:0] TOGGLE_LED_CMD = 8'h31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   // Number of protocol words in the frame for an opcode; 0 marks an unknown opcode.
   function automatic logic [2:0] cmd_words(input logic [7:0] opcode);
      case (opcode)
         RESET_CMD, TOGGLE_LED_CMD: return 3'd1;
         GET_PITCH_CMD, GET_YAW_CMD: return 3'd3;
         SET_PITCH_CMD, SET_YAW_CMD: return 3'd4;
         default:                    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: o_tick is high for one cycle every CLK_DIV cycles.
// i_restart zeroes the count so the next tick lands exactly CLK_DIV cycles later.
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   output logic o_tick
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

   // Free-running modulo-CLK_DIV counter with synchronous restart.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_cmd.sv
// Host-side SPI mode-0 master for the pan/tilt command protocol.
// One command per CS-low frame; GET frames return a 16-bit count sampled from MISO.
module spi_master_cmd
   import spi_cmd_pkg::*;
#(
   parameter int PWM_DATA_WIDTH = 16,
   parameter int QD_DATA_WIDTH  = 16,
   parameter int CLK_DIV        = 4
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      CMD_VALID,
   output logic                      CMD_READY,
   input  logic [7:0]                CMD_ID,
   input  logic                      CMD_DIR,
   input  logic [PWM_DATA_WIDTH-3:0] CMD_DUTY,
   output logic                      RSP_VALID,
   output logic [QD_DATA_WIDTH-1:0]  RSP_DATA,
   output logic                      CMD_ERR,
   output logic                      SPI_CLK,
   output logic                      SPI_CS,
   output logic                      SPI_MOSI,
   input  logic                      SPI_MISO
);

   localparam int TX_W = 4 * MSG_WIDTH;

   logic                     w_tick;
   logic                     w_accept;
   logic [2:0]               w_words;
   logic [TX_W-1:0]          w_frame;

   spi_state_t               r_state;
   logic [5:0]               r_bits;
   logic                     r_gap;
   logic                     r_is_get;
   logic [TX_W-1:0]          r_tx;
   logic [QD_DATA_WIDTH-1:0] r_rx;
   logic [QD_DATA_WIDTH-1:0] r_rsp_data;
   logic                     r_rsp_valid;
   logic                     r_err;
   logic                     r_ready;
   logic                     r_cs;
   logic                     r_clk;
   logic                     r_mosi;

   assign w_accept = CMD_VALID && r_ready;
   assign w_words  = cmd_words(CMD_ID);

   // The divider is restarted on every acceptance so the first half-period is full length.
   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_restart (w_accept),
      .o_tick    (w_tick)
   );

   // Frame image, left-aligned so the opcode MSB is shifted out first.
   always_comb begin
      w_frame = {CMD_ID, {(3 * MSG_WIDTH){1'b0}}};
      if (w_words == 3'd4) begin
         w_frame = {CMD_ID, 7'b0, CMD_DIR, 2'b0, CMD_DUTY[13:8], CMD_DUTY[7:0]};
      end
   end

   // Frame sequencer: drives CS/SCLK/MOSI, counts bits, captures MISO and issues responses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_bits      <= '0;
         r_gap       <= 1'b0;
         r_is_get    <= 1'b0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_ready     <= 1'b1;
         r_cs        <= 1'b1;
         r_clk       <= 1'b0;
         r_mosi      <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_words != 3'd0) begin
                     r_state  <= ST_SETUP;
                     r_ready  <= 1'b0;
                     r_cs     <= 1'b0;
                     r_tx     <= w_frame;
                     r_mosi   <= CMD_ID[7];
                     r_bits   <= {w_words, 3'b000};
                     r_is_get <= (w_words == 3'd3);
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               if (w_tick) begin
                  r_state <= ST_HIGH;
                  r_clk   <= 1'b1;
               end
            end
            ST_HIGH: begin
               // Falling edge: launch the next MOSI bit and sample MISO together.
               if (w_tick) begin
                  r_state <= ST_LOW;
                  r_clk   <= 1'b0;
                  r_mosi  <= r_tx[TX_W-2];
                  r_tx    <= {r_tx[TX_W-2:0], 1'b0};
                  r_rx    <= {r_rx[QD_DATA_WIDTH-2:0], SPI_MISO};
                  r_bits  <= r_bits - 6'd1;
               end
            end
            ST_LOW: begin
               if (w_tick) begin
                  if (r_bits != 6'd0) begin
                     r_state <= ST_HIGH;
                     r_clk   <= 1'b1;
                  end else begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // Only the last 16 MISO samples (words 2-3) remain in r_rx here.
               if (w_tick) begin
                  r_state <= ST_GAP;
                  r_cs    <= 1'b1;
                  r_gap   <= 1'b0;
                  if (r_is_get) begin
                     r_rsp_data  <= r_rx;
                     r_rsp_valid <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (w_tick) begin
                  if (r_gap) begin
                     r_state <= ST_IDLE;
                     r_ready <= 1'b1;
                  end else begin
                     r_gap <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_cs    <= 1'b1;
               r_clk   <= 1'b0;
            end
         endcase
      end
   end

   assign CMD_READY = r_ready;
   assign RSP_VALID = r_rsp_valid;
   assign RSP_DATA  = r_rsp_data;
   assign CMD_ERR   = r_err;
   assign SPI_CLK   = r_clk;
   assign SPI_CS    = r_cs;
   assign SPI_MOSI  = r_mosi;

endmodule

// File: tb/tb_spi_master_cmd.sv
// Directed bench for spi_master_cmd with a mode-0 slave model on the SPI pins.
module tb_spi_master_cmd;

   logic        CLK;
   logic        RST_N;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [7:0]  CMD_ID;
   logic        CMD_DIR;
   logic [13:0] CMD_DUTY;
   logic        RSP_VALID;
   logic [15:0] RSP_DATA;
   logic        CMD_ERR;
   logic        SPI_CLK;
   logic        SPI_CS;
   logic        SPI_MOSI;
   logic        SPI_MISO;

   int vectors     = 0;
   int miscompares = 0;

   // slave model / monitor state
   int          edge_cnt   = 0;
   int          edge_total = 0;
   int          cs_falls   = 0;
   logic [31:0] mosi_sr    = '0;
   logic [15:0] slave_word = '0;
   bit          slave_en   = 0;
   int          fr_edges[$];
   logic [7:0]  fr_byte[$];
   logic [31:0] fr_sr[$];

   // response tracking inside wait_ready
   int rsp_pulses  = 0;
   int rsp_at_rise = 0;
   logic prev_cs   = 1'b1;

   spi_master_cmd #(
      .PWM_DATA_WIDTH (16),
      .QD_DATA_WIDTH  (16),
      .CLK_DIV        (4)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_ID    (CMD_ID),
      .CMD_DIR   (CMD_DIR),
      .CMD_DUTY  (CMD_DUTY),
      .RSP_VALID (RSP_VALID),
      .RSP_DATA  (RSP_DATA),
      .CMD_ERR   (CMD_ERR),
      .SPI_CLK   (SPI_CLK),
      .SPI_CS    (SPI_CS),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // slave: sample MOSI and launch MISO on the rising SPI clock
   always @(posedge SPI_CLK) begin
      edge_cnt   = edge_cnt + 1;
      edge_total = edge_total + 1;
      mosi_sr    = {mosi_sr[30:0], SPI_MOSI};
      if (slave_en && edge_cnt >= 9 && edge_cnt <= 24)
         SPI_MISO = slave_word[24 - edge_cnt];
      else
         SPI_MISO = 1'b0;
   end

   always @(negedge SPI_CS) begin
      edge_cnt = 0;
      mosi_sr  = '0;
      cs_falls = cs_falls + 1;
   end

   always @(posedge SPI_CS) begin
      fr_edges.push_back(edge_cnt);
      fr_byte.push_back(mosi_sr[7:0]);
      fr_sr.push_back(mosi_sr);
   end

   task automatic send(input logic [7:0] id, input logic dir, input logic [13:0] duty);
      @(negedge CLK);
      CMD_ID    = id;
      CMD_DIR   = dir;
      CMD_DUTY  = duty;
      CMD_VALID = 1'b1;
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
   endtask

   task automatic wait_ready(output int lowc, output bit ok);
      lowc = 0;
      ok   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (RSP_VALID) begin
            rsp_pulses = rsp_pulses + 1;
            if (SPI_CS && !prev_cs) rsp_at_rise = rsp_at_rise + 1;
         end
         prev_cs = SPI_CS;
         if (CMD_READY) begin
            ok = 1'b1;
            break;
         end
         lowc = lowc + 1;
      end
   endtask

   task automatic test_reset();
      RST_N     = 1'b0;
      CMD_VALID = 1'b0;
      CMD_ID    = 8'h00;
      CMD_DIR   = 1'b0;
      CMD_DUTY  = '0;
      SPI_MISO  = 1'b0;
      repeat (3) @(negedge CLK);
      vectors++; if (SPI_CS !== 1'b1) begin miscompares++; $display("FAIL reset_cs got %b want 1", SPI_CS); end
      vectors++; if (SPI_CLK !== 1'b0) begin miscompares++; $display("FAIL reset_sclk got %b want 0", SPI_CLK); end
      vectors++; if (SPI_MOSI !== 1'b0) begin miscompares++; $display("FAIL reset_mosi got %b want 0", SPI_MOSI); end
      vectors++; if (CMD_READY !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", CMD_READY); end
      vectors++; if (RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", RSP_VALID); end
      vectors++; if (RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0000", RSP_DATA); end
      vectors++; if (CMD_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", CMD_ERR); end
      RST_N = 1'b1;
      begin
         int e0, f0, cs_low;
         e0 = edge_total; f0 = cs_falls; cs_low = 0;
         repeat (100) begin
            @(negedge CLK);
            if (SPI_CS !== 1'b1) cs_low++;
         end
         vectors++; if (edge_total != e0) begin miscompares++; $display("FAIL idle_sclk_edges got %0d want %0d", edge_total, e0); end
         vectors++; if (cs_low != 0 || cs_falls != f0) begin miscompares++; $display("FAIL idle_cs_low got %0d want 0", cs_low); end
      end
   endtask

   task automatic test_set(input logic [7:0] id, input logic dir, input logic [13:0] duty,
                           input logic [31:0] exp_sr, input string nm);
      int lowc, nfr;
      bit ok;
      nfr = fr_edges.size();
      rsp_pulses = 0;
      send(id, dir, duty);
      wait_ready(lowc, ok);
      vectors++; if (!ok || lowc != 272) begin miscompares++; $display("FAIL %s_ready_low got %0d want 272", nm, lowc); end
      vectors++; if (fr_edges.size() != nfr + 1) begin miscompares++; $display("FAIL %s_frames got %0d want 1", nm, fr_edges.size() - nfr); end
      else begin
         vectors++; if (fr_edges[nfr] != 32) begin miscompares++; $display("FAIL %s_edges got %0d want 32", nm, fr_edges[nfr]); end
         vectors++; if (fr_sr[nfr] !== exp_sr) begin miscompares++; $display("FAIL %s_mosi got %h want %h", nm, fr_sr[nfr], exp_sr); end
      end
      vectors++; if (rsp_pulses != 0) begin miscompares++; $display("FAIL %s_no_rsp got %0d want 0", nm, rsp_pulses); end
   endtask

   task automatic test_get(input logic [7:0] id, input logic [15:0] word, input string nm);
      int lowc, nfr;
      bit ok;
      nfr = fr_edges.size();
      rsp_pulses = 0; rsp_at_rise = 0; prev_cs = SPI_CS;
      slave_word = word;
      slave_en   = 1;
      send(id, 1'b0, 14'h0);
      wait_ready(lowc, ok);
      slave_en = 0;
      vectors++; if (!ok || lowc != 208) begin miscompares++; $display("FAIL %s_ready_low got %0d want 208", nm, lowc); end
      vectors++; if (fr_edges.size() != nfr + 1) begin miscompares++; $display("FAIL %s_frames got %0d want 1", nm, fr_edges.size() - nfr); end
      else begin
         vectors++; if (fr_edges[nfr] != 24) begin miscompares++; $display("FAIL %s_edges got %0d want 24", nm, fr_edges[nfr]); end
         vectors++; if (fr_sr[nfr] !== {8'h00, id, 16'h0000}) begin miscompares++; $display("FAIL %s_mosi got %h want %h", nm, fr_sr[nfr], {8'h00, id, 16'h0000}); end
      end
      vectors++; if (RSP_DATA !== word) begin miscompares++; $display("FAIL %s_rsp_data got %h want %h", nm, RSP_DATA, word); end
      vectors++; if (rsp_pulses != 1) begin miscompares++; $display("FAIL %s_rsp_pulses got %0d want 1", nm, rsp_pulses); end
      vectors++; if (rsp_at_rise != 1) begin miscompares++; $display("FAIL %s_rsp_at_cs_rise got %0d want 1", nm, rsp_at_rise); end
   endtask

   task automatic test_unknown();
      int e0, f0, errs, cs_low, not_ready;
      e0 = edge_total; f0 = cs_falls; errs = 0; cs_low = 0; not_ready = 0;
      send(8'h55, 1'b1, 14'h3FFF);
      @(negedge CLK);
      vectors++; if (CMD_ERR !== 1'b1) begin miscompares++; $display("FAIL unk_err_first got %b want 1", CMD_ERR); end
      repeat (20) begin
         @(negedge CLK);
         if (CMD_ERR) errs++;
         if (SPI_CS !== 1'b1) cs_low++;
         if (CMD_READY !== 1'b1) not_ready++;
      end
      vectors++; if (errs != 0) begin miscompares++; $display("FAIL unk_err_width got %0d extra want 0", errs); end
      vectors++; if (cs_low != 0 || cs_falls != f0) begin miscompares++; $display("FAIL unk_cs got %0d low want 0", cs_low); end
      vectors++; if (not_ready != 0) begin miscompares++; $display("FAIL unk_ready got %0d low want 0", not_ready); end
      vectors++; if (edge_total != e0) begin miscompares++; $display("FAIL unk_sclk_edges got %0d want 0", edge_total - e0); end
   endtask

   task automatic test_back_to_back();
      int lowc1, lowc2, nfr, gap, acc;
      bit ok1, ok2;
      nfr = fr_edges.size();
      gap = 0; acc = 0; lowc1 = 0; lowc2 = 0; ok2 = 0;
      @(negedge CLK);
      CMD_ID = 8'h31; CMD_VALID = 1'b1;
      if (CMD_READY) acc++;
      @(posedge CLK);
      #1 CMD_ID = 8'hFF;
      ok1 = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (fr_edges.size() == nfr + 1 && SPI_CS) gap++;
         if (CMD_READY) begin ok1 = 1; break; end
         lowc1++;
      end
      if (ok1) begin
         acc++;
         @(posedge CLK);
         #1 CMD_VALID = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (fr_edges.size() == nfr + 1 && SPI_CS) gap++;
            if (CMD_READY) begin ok2 = 1; break; end
            lowc2++;
         end
      end
      CMD_VALID = 1'b0;
      vectors++; if (!ok1 || lowc1 != 80) begin miscompares++; $display("FAIL b2b_first_low got %0d want 80", lowc1); end
      vectors++; if (!ok2 || lowc2 != 80) begin miscompares++; $display("FAIL b2b_second_low got %0d want 80", lowc2); end
      vectors++; if (acc != 2) begin miscompares++; $display("FAIL b2b_accepts got %0d want 2", acc); end
      vectors++; if (gap < 8) begin miscompares++; $display("FAIL b2b_cs_gap got %0d want >=8", gap); end
      vectors++; if (fr_edges.size() != nfr + 2) begin miscompares++; $display("FAIL b2b_frames got %0d want 2", fr_edges.size() - nfr); end
      else begin
         vectors++; if (fr_edges[nfr] != 8 || fr_byte[nfr] !== 8'h31) begin miscompares++; $display("FAIL b2b_frame1 got %0d/%h want 8/31", fr_edges[nfr], fr_byte[nfr]); end
         vectors++; if (fr_edges[nfr+1] != 8 || fr_byte[nfr+1] !== 8'hFF) begin miscompares++; $display("FAIL b2b_frame2 got %0d/%h want 8/ff", fr_edges[nfr+1], fr_byte[nfr+1]); end
      end
   endtask

   task automatic test_reset_mid();
      int lowc, nfr;
      bit ok, hit;
      send(8'h21, 1'b0, 14'h0ABC);
      hit = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge CLK);
         if (edge_cnt >= 10) begin hit = 1; break; end
      end
      vectors++; if (!hit) begin miscompares++; $display("FAIL mid_reach_word2 got timeout want edge 10"); end
      RST_N = 1'b0;
      #1;
      vectors++; if (SPI_CS !== 1'b1 || SPI_CLK !== 1'b0) begin miscompares++; $display("FAIL mid_async_reset got cs=%b sclk=%b want cs=1 sclk=0", SPI_CS, SPI_CLK); end
      vectors++; if (CMD_READY !== 1'b1 || SPI_MOSI !== 1'b0) begin miscompares++; $display("FAIL mid_reset_outs got rdy=%b mosi=%b want 1/0", CMD_READY, SPI_MOSI); end
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      nfr = fr_edges.size();
      send(8'hFF, 1'b0, 14'h0);
      wait_ready(lowc, ok);
      vectors++; if (!ok || lowc != 80) begin miscompares++; $display("FAIL mid_rst_cmd_low got %0d want 80", lowc); end
      vectors++; if (fr_edges.size() != nfr + 1) begin miscompares++; $display("FAIL mid_rst_cmd_frames got %0d want 1", fr_edges.size() - nfr); end
      else begin
         vectors++; if (fr_edges[nfr] != 8 || fr_sr[nfr] !== 32'h000000FF) begin miscompares++; $display("FAIL mid_rst_cmd_frame got %0d/%h want 8/000000ff", fr_edges[nfr], fr_sr[nfr]); end
      end
   endtask

   initial begin
      test_reset();
      test_set(8'h11, 1'b1, 14'h1234, 32'h11011234, "set_pitch");
      test_get(8'h22, 16'hBEEF, "get_yaw");
      test_get(8'h12, 16'h1357, "get_pitch");
      test_set(8'h21, 1'b0, 14'h2A5F, 32'h21002A5F, "set_yaw");
      test_unknown();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
